// File: rtl/time_pkg.sv
// rtl/time_pkg.sv - mode encodings, field limits and digit width for the time-entry clock
package time_pkg;

    typedef enum logic [2:0] {
        MODE_RUN = 3'd0,
        MODE_SEC = 3'd1,
        MODE_MIN = 3'd2,
        MODE_HR  = 3'd3
    } mode_e;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;
    localparam logic [4:0] HR_MAX  = 5'd23;

    localparam int BCD_W = 4;

endpackage

// File: rtl/bin2bcd_2dig.sv
// rtl/bin2bcd_2dig.sv - combinational 0..59 binary to two BCD digits
module bin2bcd_2dig
    import time_pkg::*;
(
    input  logic [5:0]       bin,
    output logic [BCD_W-1:0] tens,
    output logic [BCD_W-1:0] ones
);

    // Inputs never exceed 59, so both quotient and remainder fit in one digit.
    assign tens = BCD_W'(bin / 6'd10);
    assign ones = BCD_W'(bin % 6'd10);

endmodule

// File: rtl/time_entry_clock.sv
// rtl/time_entry_clock.sv - registered h:m:s clock with field entry, 12/24h display and BCD digits
module time_entry_clock
    import time_pkg::*;
#(
    parameter int TICK_DIV = 100000000,
    parameter int H24      = 1,
    parameter int VAL_W    = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       mode,
    input  logic             switch,
    input  logic [VAL_W-1:0] val,
    output logic [BCD_W-1:0] outhrstens,
    output logic [BCD_W-1:0] outhrsones,
    output logic [BCD_W-1:0] outmintens,
    output logic [BCD_W-1:0] outminones,
    output logic [BCD_W-1:0] outsectens,
    output logic [BCD_W-1:0] outsecones,
    output logic             pm,
    output logic             sec_tick,
    output logic             day_wrap,
    output logic             err
);

    localparam int DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    logic [4:0]       hr;
    logic [5:0]       min;
    logic [5:0]       sec;
    logic [DIV_W-1:0] div;
    logic [31:0]      val_ext;
    logic [5:0]       hr_disp;

    // Widen the entry so limit checks work for any bus width, including 5 bits.
    assign val_ext = 32'(val);

    // Time, divider and registered pulse outputs; entry modes take priority over counting.
    always_ff @(posedge clk) begin
        if (reset) begin
            hr       <= '0;
            min      <= '0;
            sec      <= '0;
            div      <= '0;
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            err      <= 1'b0;
        end else begin
            sec_tick <= 1'b0;
            day_wrap <= 1'b0;
            err      <= 1'b0;
            if (switch) begin
                case (mode)
                    MODE_RUN: begin
                        if (div == DIV_LAST) begin
                            div      <= '0;
                            sec_tick <= 1'b1;
                            if (sec == SEC_MAX) begin
                                sec <= '0;
                                if (min == MIN_MAX) begin
                                    min <= '0;
                                    if (hr == HR_MAX) begin
                                        hr       <= '0;
                                        day_wrap <= 1'b1;
                                    end else begin
                                        hr <= hr + 5'd1;
                                    end
                                end else begin
                                    min <= min + 6'd1;
                                end
                            end else begin
                                sec <= sec + 6'd1;
                            end
                        end else begin
                            div <= div + DIV_W'(1);
                        end
                    end
                    MODE_SEC: begin
                        // Clearing the divider gives a full second before the next tick.
                        if (val_ext <= 32'(SEC_MAX)) begin
                            sec <= val_ext[5:0];
                            div <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    MODE_MIN: begin
                        if (val_ext <= 32'(MIN_MAX)) begin
                            min <= val_ext[5:0];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    MODE_HR: begin
                        if (val_ext <= 32'(HR_MAX)) begin
                            hr <= val_ext[4:0];
                        end else begin
                            err <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // Displayed hour: identity in 24h mode, 12,1..11 mapping in 12h mode.
    always_comb begin
        hr_disp = {1'b0, hr};
        if (H24 == 0) begin
            if (hr == 5'd0) begin
                hr_disp = 6'd12;
            end else if (hr > 5'd12) begin
                hr_disp = {1'b0, hr - 5'd12};
            end
        end
    end

    assign pm = (H24 == 0) && (hr >= 5'd12);

    bin2bcd_2dig u_hr_bcd (
        .bin  (hr_disp),
        .tens (outhrstens),
        .ones (outhrsones)
    );

    bin2bcd_2dig u_min_bcd (
        .bin  (min),
        .tens (outmintens),
        .ones (outminones)
    );

    bin2bcd_2dig u_sec_bcd (
        .bin  (sec),
        .tens (outsectens),
        .ones (outsecones)
    );

endmodule

// File: tb/tb_time_entry_clock.sv
// tb/tb_time_entry_clock.sv - scoreboard bench for time_entry_clock in 24h and 12h builds
module tb_time_entry_clock;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] mode;
    logic       switch;
    logic [5:0] val;

    logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
    logic       a_pm, a_tick, a_wrap, a_err;
    logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
    logic       b_pm, b_tick, b_wrap, b_err;

    typedef struct {
        int hr;
        int mn;
        int sc;
        int tick;
        int wrap;
        int er;
    } exp_t;

    exp_t exp_q[$];

    int checks   = 0;
    int failures = 0;
    int m_hr, m_min, m_sec, m_div;
    int last_tick;

    always #5 clk = ~clk;

    time_entry_clock #(.TICK_DIV(4), .H24(1), .VAL_W(6)) dut24 (
        .clk(clk), .reset(reset), .mode(mode), .switch(switch), .val(val),
        .outhrstens(a_ht), .outhrsones(a_ho), .outmintens(a_mt), .outminones(a_mo),
        .outsectens(a_st), .outsecones(a_so), .pm(a_pm), .sec_tick(a_tick),
        .day_wrap(a_wrap), .err(a_err)
    );

    time_entry_clock #(.TICK_DIV(4), .H24(0), .VAL_W(6)) dut12 (
        .clk(clk), .reset(reset), .mode(mode), .switch(switch), .val(val),
        .outhrstens(b_ht), .outhrsones(b_ho), .outmintens(b_mt), .outminones(b_mo),
        .outsectens(b_st), .outsecones(b_so), .pm(b_pm), .sec_tick(b_tick),
        .day_wrap(b_wrap), .err(b_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int disp12(input int h);
        if (h == 0) return 12;
        if (h > 12) return h - 12;
        return h;
    endfunction

    // One clock: drive inputs, push the model's expectation, then pop and compare after the edge.
    task automatic step(input logic rst, input logic [2:0] m, input logic sw, input logic [5:0] v);
        exp_t e;
        int lim;
        reset  = rst;
        mode   = m;
        switch = sw;
        val    = v;
        e.tick = 0;
        e.wrap = 0;
        e.er   = 0;
        if (rst) begin
            m_hr = 0; m_min = 0; m_sec = 0; m_div = 0;
        end else if (sw) begin
            if (m == 3'd0) begin
                if (m_div == 3) begin
                    m_div  = 0;
                    e.tick = 1;
                    m_sec++;
                    if (m_sec == 60) begin
                        m_sec = 0;
                        m_min++;
                        if (m_min == 60) begin
                            m_min = 0;
                            m_hr++;
                            if (m_hr == 24) begin
                                m_hr   = 0;
                                e.wrap = 1;
                            end
                        end
                    end
                end else begin
                    m_div++;
                end
            end else if (m <= 3'd3) begin
                lim = (m == 3'd3) ? 23 : 59;
                if (int'(v) > lim) begin
                    e.er = 1;
                end else if (m == 3'd1) begin
                    m_sec = int'(v);
                    m_div = 0;
                end else if (m == 3'd2) begin
                    m_min = int'(v);
                end else begin
                    m_hr = int'(v);
                end
            end
        end
        e.hr = m_hr;
        e.mn = m_min;
        e.sc = m_sec;
        exp_q.push_back(e);

        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check("h24_hr_tens", a_ht, e.hr / 10);
        check("h24_hr_ones", a_ho, e.hr % 10);
        check("h24_min_tens", a_mt, e.mn / 10);
        check("h24_min_ones", a_mo, e.mn % 10);
        check("h24_sec_tens", a_st, e.sc / 10);
        check("h24_sec_ones", a_so, e.sc % 10);
        check("h24_pm", a_pm, 0);
        check("h24_sec_tick", a_tick, e.tick);
        check("h24_day_wrap", a_wrap, e.wrap);
        check("h24_err", a_err, e.er);
        check("h12_hr_tens", b_ht, disp12(e.hr) / 10);
        check("h12_hr_ones", b_ho, disp12(e.hr) % 10);
        check("h12_min_ones", b_mo, e.mn % 10);
        check("h12_sec_ones", b_so, e.sc % 10);
        check("h12_pm", b_pm, (e.hr >= 12) ? 1 : 0);
        check("h12_sec_tick", b_tick, e.tick);
        check("h12_err", b_err, e.er);
        last_tick = int'(a_tick);
    endtask

    task automatic check_hms(input string tag, input int h, input int mi, input int s);
        check({tag, "_h"}, {a_ht, a_ho}, {4'(h / 10), 4'(h % 10)});
        check({tag, "_m"}, {a_mt, a_mo}, {4'(mi / 10), 4'(mi % 10)});
        check({tag, "_s"}, {a_st, a_so}, {4'(s / 10), 4'(s % 10)});
    endtask

    task automatic set_time(input int h, input int mi, input int s);
        step(1'b0, 3'd1, 1'b1, 6'(s));
        step(1'b0, 3'd2, 1'b1, 6'(mi));
        step(1'b0, 3'd3, 1'b1, 6'(h));
    endtask

    // Runs until a tick is seen, bounded; returns the number of cycles taken (0 if none).
    task automatic run_until_tick(output int n);
        n = 0;
        for (int i = 1; i <= 8; i++) begin
            step(1'b0, 3'd0, 1'b1, 6'd0);
            if (last_tick == 1) begin
                n = i;
                break;
            end
        end
    endtask

    initial begin
        int ticks;
        int n;
        m_hr = 0; m_min = 0; m_sec = 0; m_div = 0;
        reset = 1'b1; mode = 3'd0; switch = 1'b0; val = 6'd0;
        #1;

        step(1'b1, 3'd0, 1'b0, 6'd0);
        step(1'b1, 3'd0, 1'b0, 6'd0);
        check_hms("reset", 0, 0, 0);
        check("reset_h12_tens", b_ht, 1);
        check("reset_h12_ones", b_ho, 2);

        set_time(23, 59, 55);
        check_hms("entry", 23, 59, 55);

        ticks = 0;
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 3'd0, 1'b1, 6'd0);
            ticks += last_tick;
        end
        check("run_tick_count", ticks, 4);
        check_hms("run_end", 23, 59, 59);
        run_until_tick(n);
        check("wrap_latency", n, 4);
        check_hms("wrap", 0, 0, 0);
        check("wrap_pulse", a_wrap, 1);
        step(1'b0, 3'd4, 1'b1, 6'd0);
        check("wrap_one_cycle", a_wrap, 0);

        set_time(10, 20, 30);
        step(1'b0, 3'd2, 1'b1, 6'd60);
        check("err_min", a_err, 1);
        check_hms("err_min_hold", 10, 20, 30);
        step(1'b0, 3'd3, 1'b1, 6'd24);
        check("err_hr", a_err, 1);
        step(1'b0, 3'd3, 1'b1, 6'd24);
        check("err_hr_repeat", a_err, 1);
        step(1'b0, 3'd3, 1'b0, 6'd24);
        check("err_gated", a_err, 0);
        check_hms("err_hr_hold", 10, 20, 30);

        ticks = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0, 3'd0, 1'b0, 6'd0);
            ticks += last_tick;
        end
        check("pause_ticks", ticks, 0);
        check_hms("pause_hold", 10, 20, 30);
        run_until_tick(n);
        check("resume_latency", n, 4);

        step(1'b0, 3'd0, 1'b1, 6'd0);
        step(1'b0, 3'd0, 1'b1, 6'd0);
        step(1'b0, 3'd1, 1'b1, 6'd7);
        check("divclr_sec", {a_st, a_so}, {4'd0, 4'd7});
        run_until_tick(n);
        check("divclr_latency", n, 4);

        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b1, 6'd0);
        step(1'b0, 3'd1, 1'b1, 6'd40);
        check("entry_over_tick", a_tick, 0);

        step(1'b0, 3'd5, 1'b1, 6'd9);
        for (int i = 0; i < 3; i++) step(1'b0, 3'd0, 1'b1, 6'd0);
        step(1'b1, 3'd0, 1'b1, 6'd0);
        check("reset_on_tick", a_tick, 0);

        step(1'b0, 3'd3, 1'b1, 6'd0);
        check("h12_hr0", {b_ht, b_ho, 3'd0, b_pm}, {4'd1, 4'd2, 3'd0, 1'b0});
        step(1'b0, 3'd3, 1'b1, 6'd13);
        check("h12_hr13", {b_ht, b_ho, 3'd0, b_pm}, {4'd0, 4'd1, 3'd0, 1'b1});
        step(1'b0, 3'd3, 1'b1, 6'd12);
        check("h12_hr12", {b_ht, b_ho, 3'd0, b_pm}, {4'd1, 4'd2, 3'd0, 1'b1});
        step(1'b0, 3'd3, 1'b1, 6'd23);
        for (int i = 0; i < 6; i++) step(1'b0, 3'd0, 1'b1, 6'd0);
        step(1'b1, 3'd0, 1'b1, 6'd0);
        check("h12_reset", {b_ht, b_ho, b_mt, b_mo, b_st, b_so}, {4'd1, 4'd2, 16'd0});
        check("h12_reset_pm", b_pm, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
